// File: rtl/mealy1_pkg.sv
// -----------------------------------------------------------------------------
// mealy1_pkg
// Shared definitions for the mealy1 serial sequence detector:
//   - default pattern, its length and the matching state width
//   - named states for the default 4-bit pattern
//   - seq_next(): constant function that builds the prefix/failure
//     transition table at elaboration time
// -----------------------------------------------------------------------------
package mealy1_pkg;

  localparam int                     DEF_SEQ_LEN = 4;
  localparam logic [DEF_SEQ_LEN-1:0] DEF_SEQ     = 4'b1001;
  localparam int                     DEF_ST_W    = $clog2(DEF_SEQ_LEN);
  localparam int                     MAX_SEQ_LEN = 16;

  // Named states for the default pattern: number of pattern bits matched so far.
  typedef enum logic [DEF_ST_W-1:0] {
    S0 = 2'd0,
    S1 = 2'd1,
    S2 = 2'd2,
    S3 = 2'd3
  } def_state_e;

  // State width for a given pattern length (never narrower than one bit).
  function automatic int seq_st_w(input int len);
    int w;
    if (len < 2) begin
      w = 1;
    end else begin
      w = $clog2(len);
    end
    return w;
  endfunction

  // Next state after seeing bit b while k pattern bits are matched.
  // seq holds the pattern right-aligned, MSB (bit len-1) received first.
  // The result is the longest prefix of the pattern (shorter than len) that
  // is a suffix of the k matched bits followed by b. A correct bit before the
  // last one therefore simply advances; a full match falls back to the
  // longest border of the pattern, or to 0 when overlapping is disabled.
  function automatic int seq_next(input logic [15:0] seq, input int len,
                                  input int k, input logic b, input bit overlap);
    logic [16:0] str;
    int          best;
    int          lim;
    bit          ok;
    bit          full;
    str  = 17'd0;
    best = 0;
    for (int i = 0; i < k; i++) begin
      str[i] = seq[len-1-i];
    end
    str[k] = b;
    full   = (k == len - 1) && (b == seq[0]);
    lim    = (k + 1 < len - 1) ? (k + 1) : (len - 1);
    if (full && !overlap) begin
      best = 0;
    end else begin
      for (int l = 1; l <= lim; l++) begin
        ok = 1'b1;
        for (int j = 0; j < l; j++) begin
          if (str[k+1-l+j] != seq[len-1-j]) begin
            ok = 1'b0;
          end
        end
        if (ok) begin
          best = l;
        end
      end
    end
    return best;
  endfunction

endpackage

// File: rtl/mealy1_next.sv
// -----------------------------------------------------------------------------
// mealy1_next
// Pure combinational next-state and detect logic for the mealy1 detector.
// The transition table is fully resolved at elaboration from SEQ.
// Ports:
//   i_state  current matched-prefix length
//   i_ip     current serial input bit
//   o_next   next matched-prefix length
//   o_hit    pattern completes with the current bit (not reset-gated here)
// -----------------------------------------------------------------------------
module mealy1_next
  import mealy1_pkg::*;
#(
  parameter int                 SEQ_LEN = DEF_SEQ_LEN,
  parameter logic [SEQ_LEN-1:0] SEQ     = DEF_SEQ,
  parameter bit                 OVERLAP = 1'b1,
  parameter int                 ST_W    = seq_st_w(SEQ_LEN)
) (
  input  logic [ST_W-1:0] i_state,
  input  logic            i_ip,
  output logic [ST_W-1:0] o_next,
  output logic            o_hit
);

  localparam int          NS    = 2 ** ST_W;
  localparam logic [15:0] SEQ16 = 16'(SEQ);
  localparam logic [ST_W-1:0] LAST = ST_W'(SEQ_LEN - 1);

  logic [ST_W-1:0] w_tbl [0:NS-1][0:1];

  // Unreachable encodings (when SEQ_LEN is not a power of two) map back to 0.
  for (genvar gk = 0; gk < NS; gk++) begin : g_st
    for (genvar gb = 0; gb < 2; gb++) begin : g_bit
      if (gk < SEQ_LEN) begin : g_live
        localparam int NXT = seq_next(SEQ16, SEQ_LEN, gk, 1'(gb), OVERLAP);
        assign w_tbl[gk][gb] = ST_W'(NXT);
      end else begin : g_dead
        assign w_tbl[gk][gb] = '0;
      end
    end
  end

  // Table lookup for the next state and the Mealy detect condition.
  always_comb begin
    o_next = '0;
    o_hit  = 1'b0;
    if (int'(i_state) < SEQ_LEN) begin
      o_next = w_tbl[i_state][i_ip];
      o_hit  = (i_state == LAST) && (i_ip == SEQ[0]);
    end else begin
      o_next = '0;
      o_hit  = 1'b0;
    end
  end

endmodule

// File: rtl/mealy1.sv
// -----------------------------------------------------------------------------
// mealy1
// Mealy serial sequence detector: raises op in the same cycle the final
// pattern bit is present on ip. Holds only the state register; transition
// logic lives in mealy1_next.
// Ports:
//   clk    rising-edge clock
//   reset  synchronous active-low reset (0 clears any partial match)
//   ip     serial data bit, first pattern bit received first
//   op     combinational one-cycle detect strobe, forced low during reset
// -----------------------------------------------------------------------------
module mealy1
  import mealy1_pkg::*;
#(
  parameter int                 SEQ_LEN = DEF_SEQ_LEN,
  parameter logic [SEQ_LEN-1:0] SEQ     = DEF_SEQ,
  parameter bit                 OVERLAP = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic ip,
  output logic op
);

  localparam int ST_W = seq_st_w(SEQ_LEN);

  logic [ST_W-1:0] r_state;
  logic [ST_W-1:0] w_next;
  logic            w_hit;

  mealy1_next #(
    .SEQ_LEN (SEQ_LEN),
    .SEQ     (SEQ),
    .OVERLAP (OVERLAP),
    .ST_W    (ST_W)
  ) u_next (
    .i_state (r_state),
    .i_ip    (ip),
    .o_next  (w_next),
    .o_hit   (w_hit)
  );

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= '0;
    end else begin
      r_state <= w_next;
    end
  end

  // The strobe must stay low while reset is held, whatever the state holds.
  assign op = w_hit & reset;

endmodule

// File: tb/tb_mealy1.sv
// -----------------------------------------------------------------------------
// tb_mealy1
// Table-driven bench for mealy1 with a scoreboard queue. Three instances share
// clk/reset/ip: default pattern with overlap (a), without overlap (b), and a
// 3-bit pattern 110 (c). Each vector carries a mask of instances to check.
// -----------------------------------------------------------------------------
module tb_mealy1;

  typedef struct {
    logic       rst;
    logic       ip;
    logic [2:0] chk;
    logic [2:0] exp;
  } vec_t;

  logic clk;
  logic reset;
  logic ip;
  logic op_a;
  logic op_b;
  logic op_c;

  int n_vec;
  int n_err;

  vec_t vecs[$];
  vec_t sb[$];

  mealy1 u_a (.clk(clk), .reset(reset), .ip(ip), .op(op_a));

  mealy1 #(.OVERLAP(1'b0)) u_b (.clk(clk), .reset(reset), .ip(ip), .op(op_b));

  mealy1 #(.SEQ_LEN(3), .SEQ(3'b110)) u_c (.clk(clk), .reset(reset), .ip(ip), .op(op_c));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic add(input logic r, input logic b, input logic [2:0] chk,
                     input logic [2:0] exp);
    vec_t v;
    v.rst = r;
    v.ip  = b;
    v.chk = chk;
    v.exp = exp;
    vecs.push_back(v);
  endtask

  task automatic check1(input string name, input logic act, input logic req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: op=%b expected %b at %0t", name, act, req, $time);
    end
  endtask

  int stream2[23] = '{0,1,1,0,0,0,1,0,0,1,0,0,1,1,0,1,0,1,0,0,1,0,1};

  initial begin
    vec_t       v;
    logic [2:0] act;
    n_vec = 0;
    n_err = 0;
    reset = 1'b0;
    ip    = 1'b1;

    // Reset held two cycles with ip=1: no strobe anywhere.
    add(1'b0, 1'b1, 3'b111, 3'b000);
    add(1'b0, 1'b1, 3'b111, 3'b000);
    // Long stream: hits on bits 10, 13, 21 with overlap; 10, 21 without.
    for (int i = 0; i < 23; i++) begin
      add(1'b1, 1'(stream2[i]), 3'b011,
          {1'b0, 1'((i == 9) || (i == 20)), 1'((i == 9) || (i == 12) || (i == 20))});
    end
    // Partial match 1,0,0 then reset with ip=1 (gated), then 1 -> no strobe.
    add(1'b0, 1'b0, 3'b111, 3'b000);
    add(1'b1, 1'b1, 3'b011, 3'b000);
    add(1'b1, 1'b0, 3'b011, 3'b000);
    add(1'b1, 1'b0, 3'b011, 3'b000);
    add(1'b0, 1'b1, 3'b111, 3'b000);
    add(1'b1, 1'b1, 3'b011, 3'b000);
    // Pattern 110: stream 1,1,1,0 hits on the 4th bit, then 1,1,0 again on 3rd.
    add(1'b0, 1'b0, 3'b111, 3'b000);
    add(1'b1, 1'b1, 3'b100, 3'b000);
    add(1'b1, 1'b1, 3'b100, 3'b000);
    add(1'b1, 1'b1, 3'b100, 3'b000);
    add(1'b1, 1'b0, 3'b100, 3'b100);
    add(1'b1, 1'b1, 3'b100, 3'b000);
    add(1'b1, 1'b1, 3'b100, 3'b000);
    add(1'b1, 1'b0, 3'b100, 3'b100);

    foreach (vecs[i]) begin
      @(negedge clk);
      reset = vecs[i].rst;
      ip    = vecs[i].ip;
      sb.push_back(vecs[i]);
      #2;
      v   = sb.pop_front();
      act = {op_c, op_b, op_a};
      for (int k = 0; k < 3; k++) begin
        if (v.chk[k]) begin
          check1($sformatf("vec%0d_inst%0d", i, k), act[k], v.exp[k]);
        end
      end
    end

    // Mealy timing: reach S3 on instance a, then wiggle ip within one cycle.
    @(negedge clk);
    reset = 1'b0;
    ip    = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    ip    = 1'b1;
    @(negedge clk);
    ip = 1'b0;
    @(negedge clk);
    ip = 1'b0;
    @(negedge clk);
    ip = 1'b0;
    #1;
    check1("mealy_low", op_a, 1'b0);
    ip = 1'b1;
    #1;
    check1("mealy_rise", op_a, 1'b1);
    ip = 1'b0;
    #1;
    check1("mealy_fall", op_a, 1'b0);
    // Falling back to S0 on the 0: a lone 1 next cycle must not strobe.
    @(negedge clk);
    ip = 1'b1;
    #1;
    check1("mealy_after", op_a, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
